// File: rtl/lenet_pkg.sv
// Shared LeNet-5 datapath constants and the pixel type used between stages.
package lenet_pkg;

  localparam int DATA_W   = 12;
  localparam int C3_MAP_W = 10;
  localparam int C3_MAP_H = 10;
  localparam int S4_MAP_W = C3_MAP_W / 2;
  localparam int S4_MAP_H = C3_MAP_H / 2;

  typedef logic signed [DATA_W-1:0] pixel_t;

endpackage

// File: rtl/stage2_pool_if.sv
// Pixel stream into and pooled stream out of the S4 max-pool stage.
interface stage2_pool_if #(
  parameter int DATA_W = lenet_pkg::DATA_W
);

  logic                     in_valid;
  logic signed [DATA_W-1:0] in_data;
  logic                     out_valid;
  logic signed [DATA_W-1:0] out_data;
  logic                     out_last;

  modport master (output in_valid, in_data, input out_valid, out_data, out_last);
  modport slave  (input in_valid, in_data, output out_valid, out_data, out_last);

endinterface

// File: rtl/pool_max2.sv
// Combinational signed 2-input max; build with STAGE2_POOL_RELU_EN to clamp
// negative results to zero (equivalent to clamping every input pixel first).
module pool_max2 #(
  parameter int DATA_W = lenet_pkg::DATA_W
) (
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_i,
  output logic signed [DATA_W-1:0] max_o
);

  logic signed [DATA_W-1:0] max_raw;

  assign max_raw = (a_i > b_i) ? a_i : b_i;

`ifdef STAGE2_POOL_RELU_EN
  assign max_o = max_raw[DATA_W-1] ? '0 : max_raw;
`else
  assign max_o = max_raw;
`endif

endmodule

// File: rtl/stage2_pool.sv
// S4 2x2 stride-2 max pooling over the summed C3 stream, with its own line
// buffer and row/column sequencing. Optional ReLU via STAGE2_POOL_RELU_EN.
module stage2_pool #(
  parameter int DATA_W = lenet_pkg::DATA_W,
  parameter int MAP_W  = lenet_pkg::C3_MAP_W,
  parameter int MAP_H  = lenet_pkg::C3_MAP_H
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_clr,
  stage2_pool_if.slave  bus
);
  import lenet_pkg::*;

  localparam int COL_W = (MAP_W > 2) ? $clog2(MAP_W) : 2;
  localparam int ROW_W = (MAP_H > 2) ? $clog2(MAP_H) : 2;
  localparam int LB_N  = MAP_W / 2;

  localparam logic [0:0] EVEN_ROW = 1'b0;
  localparam logic [0:0] ODD_ROW  = 1'b1;

  if ((MAP_W % 2) != 0 || (MAP_H % 2) != 0) begin : g_bad_map
    $error("stage2_pool: MAP_W and MAP_H must both be even");
  end

  logic [COL_W-1:0]         col_q, col_d;
  logic [ROW_W-1:0]         row_q, row_d;
  logic [0:0]               phase_q, phase_d;
  logic signed [DATA_W-1:0] hold_q, hold_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [DATA_W-1:0] out_data_q, out_data_d;
  logic                     out_last_q, out_last_d;

  logic signed [DATA_W-1:0] linebuf [LB_N];
  logic signed [DATA_W-1:0] lb_rd_q;
  logic signed [DATA_W-1:0] hmax;
  logic signed [DATA_W-1:0] vmax;
  logic                     accept;
  logic                     col_last;
  logic                     row_last;
  logic [COL_W-2:0]         lb_addr;

  assign accept   = bus.in_valid & ~frame_clr;
  assign col_last = (col_q == COL_W'(MAP_W - 1));
  assign row_last = (row_q == ROW_W'(MAP_H - 1));
  assign lb_addr  = col_q[COL_W-1:1];

  pool_max2 #(.DATA_W(DATA_W)) u_hmax (
    .a_i   (hold_q),
    .b_i   (bus.in_data),
    .max_o (hmax)
  );

  pool_max2 #(.DATA_W(DATA_W)) u_vmax (
    .a_i   (lb_rd_q),
    .b_i   (hmax),
    .max_o (vmax)
  );

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    phase_d     = phase_q;
    hold_d      = hold_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_last_d  = 1'b0;
    if (frame_clr) begin
      col_d   = '0;
      row_d   = '0;
      phase_d = EVEN_ROW;
      hold_d  = '0;
    end else if (bus.in_valid) begin
      if (!col_q[0]) begin
        hold_d = bus.in_data;
      end
      if (col_last) begin
        col_d   = '0;
        row_d   = row_last ? '0 : row_q + ROW_W'(1);
        phase_d = (phase_q == EVEN_ROW) ? ODD_ROW : EVEN_ROW;
      end else begin
        col_d = col_q + COL_W'(1);
      end
      // Second beat of the second row of a window completes the 2x2 max.
      if (col_q[0] && phase_q == ODD_ROW) begin
        out_valid_d = 1'b1;
        out_data_d  = vmax;
        out_last_d  = row_last & col_last;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      phase_q     <= EVEN_ROW;
      hold_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      phase_q     <= phase_d;
      hold_q      <= hold_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  // Line buffer: odd-row reads are issued on the even column so the stored
  // horizontal max is already registered when the odd column arrives.
  always_ff @(posedge clk) begin
    if (accept && phase_q == EVEN_ROW && col_q[0]) begin
      linebuf[lb_addr] <= hmax;
    end
    if (accept && phase_q == ODD_ROW && !col_q[0]) begin
      lb_rd_q <= linebuf[lb_addr];
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;

endmodule
